// File: rtl/chip_seq_ctrl.sv
// Fluidic sequencer for the sample-prep chip. It fills the prep chamber, moves the
// sample through the shared reaction chamber and drives the peristaltic pump.
module chip_seq_ctrl #(
    parameter int CNT_W    = 16,
    parameter int PUMP_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       inlet_sel,
    input  logic [CNT_W-1:0] fill_cycles,
    input  logic [CNT_W-1:0] incubate_steps,
    input  logic [CNT_W-1:0] wash_cycles,
    input  logic [CNT_W-1:0] collect_cycles,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [4:0]       inlet_ctrl,
    output logic [6:0]       prep_ctrl,
    output logic [6:0]       stage_ctrl,
    output logic [2:0]       pump
);

    // state     | meaning
    // ----------+-----------------------------------------------
    // S_IDLE    | all valves closed, waiting for start
    // S_FILL    | selected inlet into prep chamber
    // S_TRANSFER| prep chamber into reaction chamber
    // S_BEAD    | bead loading, sieve closed to trap beads
    // S_INCUBATE| all valves closed, peristaltic pump mixing
    // S_WASH    | flush through reaction chamber, sieve closed
    // S_COLLECT | sample out through sieve to collect port
    // S_DONE    | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_TRANSFER, S_BEAD, S_INCUBATE, S_WASH, S_COLLECT, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       DIV_LOAD = 8'(PUMP_DIV - 1);
    localparam logic [18:0]      ALL_SHUT = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rev;
    logic [7:0]       div;
    logic [2:0]       phase;
    logic [CNT_W-1:0] fill_m1;
    logic [CNT_W-1:0] steps_m1;
    logic [CNT_W-1:0] wash_m1;
    logic [CNT_W-1:0] collect_m1;

    // Down-counter load value; a zero duration behaves like one cycle.
    function automatic logic [CNT_W-1:0] last(input logic [CNT_W-1:0] n);
        return (n == '0) ? '0 : n - ONE;
    endfunction

    function automatic logic [2:0] pump_pat(input logic [2:0] ph);
        case (ph)
            3'd0:    return 3'b110;
            3'd1:    return 3'b100;
            3'd2:    return 3'b101;
            3'd3:    return 3'b001;
            3'd4:    return 3'b011;
            3'd5:    return 3'b010;
            default: return 3'b111;
        endcase
    endfunction

    // Returns {inlet_ctrl, prep_ctrl, stage_ctrl}; 1 = closed.
    function automatic logic [18:0] valves(input state_t st, input logic [2:0] sel);
        logic [4:0] inl;
        logic [6:0] prep;
        logic [6:0] stg;
        inl  = '1;
        prep = '1;
        stg  = '1;
        case (st)
            S_FILL: begin
                case (sel)
                    3'd1:    inl = 5'b11110;
                    3'd2:    inl = 5'b11101;
                    3'd3:    inl = 5'b11011;
                    3'd4:    inl = 5'b10111;
                    3'd5:    inl = 5'b01111;
                    default: inl = 5'b11111;
                endcase
                prep = 7'b0111110;
            end
            S_TRANSFER: begin
                prep = 7'b1111101;
                stg  = 7'b1111100;
            end
            S_BEAD:    stg = 7'b0011111;
            S_WASH:    stg = 7'b1001111;
            S_COLLECT: stg = 7'b1100011;
            default: ;
        endcase
        return {inl, prep, stg};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            rev        <= '0;
            div        <= '0;
            phase      <= '0;
            fill_m1    <= '0;
            steps_m1   <= '0;
            wash_m1    <= '0;
            collect_m1 <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            {inlet_ctrl, prep_ctrl, stage_ctrl} <= ALL_SHUT;
            pump       <= 3'b111;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                {inlet_ctrl, prep_ctrl, stage_ctrl} <= ALL_SHUT;
                pump  <= 3'b111;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            if (inlet_sel >= 3'd1 && inlet_sel <= 3'd5) begin
                                fill_m1    <= last(fill_cycles);
                                steps_m1   <= last(incubate_steps);
                                wash_m1    <= last(wash_cycles);
                                collect_m1 <= last(collect_cycles);
                                cnt        <= last(fill_cycles);
                                state      <= S_FILL;
                                busy       <= 1'b1;
                                {inlet_ctrl, prep_ctrl, stage_ctrl} <= valves(S_FILL, inlet_sel);
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
                    S_FILL: begin
                        if (cnt == '0) begin
                            state <= S_TRANSFER;
                            cnt   <= fill_m1;
                            {inlet_ctrl, prep_ctrl, stage_ctrl} <= valves(S_TRANSFER, 3'd0);
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    S_TRANSFER: begin
                        if (cnt == '0) begin
                            state <= S_BEAD;
                            cnt   <= fill_m1;
                            {inlet_ctrl, prep_ctrl, stage_ctrl} <= valves(S_BEAD, 3'd0);
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    S_BEAD: begin
                        if (cnt == '0) begin
                            state <= S_INCUBATE;
                            rev   <= steps_m1;
                            div   <= DIV_LOAD;
                            phase <= 3'd0;
                            pump  <= pump_pat(3'd0);
                            {inlet_ctrl, prep_ctrl, stage_ctrl} <= ALL_SHUT;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    S_INCUBATE: begin
                        // div paces each pump step, phase walks the 6-step pattern, rev counts revolutions
                        if (div != 8'd0) begin
                            div <= div - 8'd1;
                        end else begin
                            div <= DIV_LOAD;
                            if (phase == 3'd5) begin
                                phase <= 3'd0;
                                if (rev == '0) begin
                                    state <= S_WASH;
                                    cnt   <= wash_m1;
                                    pump  <= 3'b111;
                                    {inlet_ctrl, prep_ctrl, stage_ctrl} <= valves(S_WASH, 3'd0);
                                end else begin
                                    rev  <= rev - ONE;
                                    pump <= pump_pat(3'd0);
                                end
                            end else begin
                                phase <= phase + 3'd1;
                                pump  <= pump_pat(phase + 3'd1);
                            end
                        end
                    end
                    S_WASH: begin
                        if (cnt == '0) begin
                            state <= S_COLLECT;
                            cnt   <= collect_m1;
                            {inlet_ctrl, prep_ctrl, stage_ctrl} <= valves(S_COLLECT, 3'd0);
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    S_COLLECT: begin
                        if (cnt == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            {inlet_ctrl, prep_ctrl, stage_ctrl} <= ALL_SHUT;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        {inlet_ctrl, prep_ctrl, stage_ctrl} <= ALL_SHUT;
                        pump  <= 3'b111;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chip_seq_ctrl.sv
// Directed bench for chip_seq_ctrl: every output is compared each cycle of a run
// against hand-written per-state valve words and durations.
module tb_chip_seq_ctrl;

    localparam int CW = 8;
    localparam int PD = 4;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [2:0]    inlet_sel;
    logic [CW-1:0] fill_cycles, incubate_steps, wash_cycles, collect_cycles;
    logic          busy, done, error;
    logic [4:0]    inlet_ctrl;
    logic [6:0]    prep_ctrl, stage_ctrl;
    logic [2:0]    pump;
    logic [24:0]   obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chip_seq_ctrl #(.CNT_W(CW), .PUMP_DIV(PD)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .inlet_sel(inlet_sel),
        .fill_cycles(fill_cycles), .incubate_steps(incubate_steps),
        .wash_cycles(wash_cycles), .collect_cycles(collect_cycles),
        .busy(busy), .done(done), .error(error), .inlet_ctrl(inlet_ctrl),
        .prep_ctrl(prep_ctrl), .stage_ctrl(stage_ctrl), .pump(pump)
    );

    assign obs = {busy, done, error, inlet_ctrl, prep_ctrl, stage_ctrl, pump};

    // {busy, done, error, inlet, prep, stage, pump}
    localparam logic [24:0] V_IDLE = {3'b000, 5'h1f, 7'h7f, 7'h7f, 3'b111};
    localparam logic [24:0] V_ERR  = {3'b001, 5'h1f, 7'h7f, 7'h7f, 3'b111};
    localparam logic [24:0] V_XFER = {3'b100, 5'h1f, 7'b1111101, 7'b1111100, 3'b111};
    localparam logic [24:0] V_BEAD = {3'b100, 5'h1f, 7'h7f, 7'b0011111, 3'b111};
    localparam logic [24:0] V_WASH = {3'b100, 5'h1f, 7'h7f, 7'b1001111, 3'b111};
    localparam logic [24:0] V_COLL = {3'b100, 5'h1f, 7'h7f, 7'b1100011, 3'b111};
    localparam logic [24:0] V_DONE = {3'b110, 5'h1f, 7'h7f, 7'h7f, 3'b111};

    function automatic logic [24:0] vfill(input logic [2:0] sel);
        logic [4:0] inl;
        case (sel)
            3'd1:    inl = 5'b11110;
            3'd2:    inl = 5'b11101;
            3'd3:    inl = 5'b11011;
            3'd4:    inl = 5'b10111;
            default: inl = 5'b01111;
        endcase
        return {3'b100, inl, 7'b0111110, 7'h7f, 3'b111};
    endfunction

    function automatic logic [24:0] vinc(input int p);
        logic [2:0] pm;
        case (p)
            0:       pm = 3'b110;
            1:       pm = 3'b100;
            2:       pm = 3'b101;
            3:       pm = 3'b001;
            4:       pm = 3'b011;
            default: pm = 3'b010;
        endcase
        return {3'b100, 5'h1f, 7'h7f, 7'h7f, pm};
    endfunction

    function automatic int eff(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_seg(input string tag, input int n, input logic [24:0] v);
        for (int i = 0; i < n; i++) begin
            chk(tag, obs, v);
            tick();
        end
    endtask

    // Issues start, then scrambles the config inputs so any late sampling shows up.
    task automatic start_run(input logic [2:0] sel, input int f, input int s, input int w, input int c);
        inlet_sel      = sel;
        fill_cycles    = f[CW-1:0];
        incubate_steps = s[CW-1:0];
        wash_cycles    = w[CW-1:0];
        collect_cycles = c[CW-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        inlet_sel      = 3'd7;
        fill_cycles    = 8'd77;
        incubate_steps = 8'd3;
        wash_cycles    = 8'd50;
        collect_cycles = 8'd60;
    endtask

    task automatic check_run(input logic [2:0] sel, input int f, input int s, input int w, input int c);
        expect_seg("fill", eff(f), vfill(sel));
        expect_seg("transfer", eff(f), V_XFER);
        expect_seg("bead", eff(f), V_BEAD);
        for (int r = 0; r < eff(s); r++)
            for (int p = 0; p < 6; p++)
                expect_seg("incubate", PD, vinc(p));
        expect_seg("wash", eff(w), V_WASH);
        expect_seg("collect", eff(c), V_COLL);
        expect_seg("done", 1, V_DONE);
        chk("idle_after", obs, V_IDLE);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        inlet_sel = 3'd3; fill_cycles = '0; incubate_steps = '0;
        wash_cycles = '0; collect_cycles = '0;
        repeat (3) tick();
        chk("reset", obs, V_IDLE);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("abort_idle", obs, V_IDLE);
        abort = 1'b0;
        tick();

        // nominal run, busy spans 2+2+2+24+3+2+1 = 36 cycles
        start_run(3'd3, 2, 1, 3, 2);
        check_run(3'd3, 2, 1, 3, 2);

        // rejected selects
        inlet_sel = 3'd0; start = 1'b1; tick(); start = 1'b0;
        chk("err_sel0", obs, V_ERR);
        tick();
        chk("err_clear0", obs, V_IDLE);
        inlet_sel = 3'd6; start = 1'b1; tick(); start = 1'b0;
        chk("err_sel6", obs, V_ERR);
        tick();
        chk("err_clear6", obs, V_IDLE);
        inlet_sel = 3'd7; start = 1'b1; tick(); start = 1'b0;
        chk("err_sel7", obs, V_ERR);
        tick();

        // zero durations: 1+1+1+24+1+1 cycles, then done
        start_run(3'd5, 0, 0, 0, 0);
        check_run(3'd5, 0, 0, 0, 0);

        // abort during the third pump step, restart on the very next cycle
        start_run(3'd2, 1, 2, 1, 1);
        expect_seg("fill_a", 1, vfill(3'd2));
        expect_seg("transfer_a", 1, V_XFER);
        expect_seg("bead_a", 1, V_BEAD);
        expect_seg("inc_a0", PD, vinc(0));
        expect_seg("inc_a1", PD, vinc(1));
        chk("inc_a2", obs, vinc(2));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_inc", obs, V_IDLE);
        start_run(3'd4, 0, 0, 0, 0);
        check_run(3'd4, 0, 0, 0, 0);

        // abort on the expiring cycle of TRANSFER
        start_run(3'd1, 2, 1, 1, 1);
        expect_seg("fill_b", 2, vfill(3'd1));
        expect_seg("transfer_b", 1, V_XFER);
        chk("transfer_b_last", obs, V_XFER);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_expiry", obs, V_IDLE);
        tick();
        chk("abort_no_done", obs, V_IDLE);

        // start while busy is ignored; reset mid-WASH wins over start
        start_run(3'd3, 2, 1, 4, 2);
        expect_seg("fill_c", 2, vfill(3'd3));
        inlet_sel = 3'd1; fill_cycles = 8'd9; start = 1'b1;
        expect_seg("transfer_c", 2, V_XFER);
        start = 1'b0;
        expect_seg("bead_c", 2, V_BEAD);
        for (int p = 0; p < 6; p++)
            expect_seg("inc_c", PD, vinc(p));
        expect_seg("wash_c", 2, V_WASH);
        rst = 1'b1; start = 1'b1; inlet_sel = 3'd2;
        tick();
        chk("rst_wash", obs, V_IDLE);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("rst_idle", obs, V_IDLE);
        start_run(3'd2, 1, 1, 1, 1);
        check_run(3'd2, 1, 1, 1, 1);

        // largest counter values are honoured without wrap
        start_run(3'd5, 255, 1, 255, 255);
        check_run(3'd5, 255, 1, 255, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
